imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_pkg.sv | 41 ++++
 rtl/imm_ext_core.sv | 38 +++
 rtl/imm_decode_stage.sv | 73 +++++++
 tb/tb_imm_decode_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Immediate format encodings and RV32 opcode constants, shared between the
// decode stage and the single-cycle core's control unit.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I   = 3'b000,
    FMT_S   = 3'b001,
    FMT_B   = 3'b010,
    FMT_U   = 3'b011,
    FMT_J   = 3'b100,
    FMT_Z   = 3'b101,
    FMT_RS6 = 3'b110,
    FMT_RS7 = 3'b111
  } imm_fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // CSR-immediate forms (funct3[2]=1) carry a 5-bit zimm; other SYSTEM ops use I.
  function automatic imm_fmt_e opcode_fmt(input logic [31:0] instr);
    imm_fmt_e fmt;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
      OP_STORE:                 fmt = FMT_S;
      OP_BRANCH:                fmt = FMT_B;
      OP_LUI, OP_AUIPC:         fmt = FMT_U;
      OP_JAL:                   fmt = FMT_J;
      OP_SYSTEM:                fmt = instr[14] ? FMT_Z : FMT_I;
      default:                  fmt = FMT_RS7;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extraction: resolves the format (explicit or from
// the opcode) and builds the sign- or zero-extended immediate.
module imm_ext_core
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b0
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      sel_in,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      sel,
  output logic            illegal
);

  imm_fmt_e    fmt;
  logic [31:0] raw;

  // raw is the 32-bit immediate; widening it as signed gives the XLEN result,
  // and the Z form leaves bit 31 clear so it comes out zero-extended.
  always_comb begin
    fmt     = AUTO_DECODE ? opcode_fmt(instr) : imm_fmt_e'(sel_in);
    raw     = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_I:   raw = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   raw = {instr[31:12], 12'b0};
      FMT_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_Z:   raw = {27'b0, instr[19:15]};
      default: illegal = 1'b1;
    endcase
    sel = fmt;
    imm = XLEN'($signed(raw));
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode pipeline stage: extraction ahead of a 2-entry skid buffer
// (main + skid) so in_ready never depends combinationally on out_ready.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_imm_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_sel,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      sel;
    logic            illegal;
  } entry_t;

  entry_t ext, main_q, skid_q;
  logic   main_valid, skid_valid;
  logic   in_fire;

  imm_ext_core #(.XLEN(XLEN), .AUTO_DECODE(AUTO_DECODE)) u_ext (
    .instr   (in_instr),
    .sel_in  (in_imm_sel),
    .imm     (ext.imm),
    .sel     (ext.sel),
    .illegal (ext.illegal)
  );

  assign in_ready    = ~skid_valid;
  assign in_fire     = in_valid & in_ready;
  assign out_valid   = main_valid;
  assign out_imm     = main_q.imm;
  assign out_sel     = main_q.sel;
  assign out_illegal = main_q.illegal;

  // Skid is only ever valid while main is valid, so an empty main never has
  // to look at skid; a refill from skid always wins because in_ready is low then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_ready) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= in_fire;
        if (in_fire) main_q <= ext;
      end
    end else if (in_fire) begin
      skid_q     <= ext;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: three instances (32-bit, 64-bit, auto-decode)
// share one stimulus stream and are checked against a queue-based model.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_sel;

  logic        r32, v32, ill32;
  logic [31:0] imm32;
  logic [2:0]  sel32;
  logic        r64, v64, ill64;
  logic [63:0] imm64;
  logic [2:0]  sel64;
  logic        ra, va, illa;
  logic [31:0] imma;
  logic [2:0]  sela;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
  } item_t;
  item_t q[$];

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .AUTO_DECODE(1'b0)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_sel(sel32), .out_illegal(ill32));

  imm_decode_stage #(.XLEN(64), .AUTO_DECODE(1'b0)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_sel(sel64), .out_illegal(ill64));

  imm_decode_stage #(.XLEN(32), .AUTO_DECODE(1'b1)) duta (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ra),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .out_valid(va), .out_ready(out_ready),
    .out_imm(imma), .out_sel(sela), .out_illegal(illa));

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: immediate value as a signed integer built from field weights.
  function automatic void ref_decode(input logic [31:0] ins, input logic [2:0] sel_in,
                                     input bit autod, output longint imm,
                                     output logic [2:0] rsel, output bit ill);
    longint u;
    u    = longint'({32'b0, ins});
    rsel = sel_in;
    if (autod) begin
      case (ins[6:0])
        7'h13, 7'h03, 7'h67: rsel = 3'd0;
        7'h23:               rsel = 3'd1;
        7'h63:               rsel = 3'd2;
        7'h37, 7'h17:        rsel = 3'd3;
        7'h6F:               rsel = 3'd4;
        7'h73:               rsel = ins[14] ? 3'd5 : 3'd0;
        default:             rsel = 3'd7;
      endcase
    end
    ill = 1'b0;
    imm = 0;
    case (rsel)
      3'd0: begin imm = (u >> 20) & 4095; if (imm >= 2048) imm -= 4096; end
      3'd1: begin
        imm = (((u >> 25) & 127) << 5) + ((u >> 7) & 31);
        if (imm >= 2048) imm -= 4096;
      end
      3'd2: begin
        imm = (((u >> 31) & 1) << 12) + (((u >> 7) & 1) << 11)
            + (((u >> 25) & 63) << 5) + (((u >> 8) & 15) << 1);
        if (imm >= 4096) imm -= 8192;
      end
      3'd3: begin
        imm = (u >> 12) << 12;
        if (imm >= 64'sd2147483648) imm -= 64'sd4294967296;
      end
      3'd4: begin
        imm = (((u >> 31) & 1) << 20) + (((u >> 12) & 255) << 12)
            + (((u >> 20) & 1) << 11) + (((u >> 21) & 1023) << 1);
        if (imm >= (64'sd1 << 20)) imm -= (64'sd1 << 21);
      end
      3'd5: imm = (u >> 15) & 31;
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic checkAll();
    longint      e;
    logic [2:0]  s;
    bit          il;
    logic [63:0] ev;
    logic [63:0] er;
    ev = {63'b0, q.size() != 0};
    er = {63'b0, q.size() < 2};
    checkOutput("valid32", {63'b0, v32}, ev);
    checkOutput("valid64", {63'b0, v64}, ev);
    checkOutput("valida",  {63'b0, va},  ev);
    checkOutput("ready32", {63'b0, r32}, er);
    checkOutput("ready64", {63'b0, r64}, er);
    checkOutput("readya",  {63'b0, ra},  er);
    if (q.size() != 0) begin
      ref_decode(q[0].instr, q[0].sel, 1'b0, e, s, il);
      checkOutput("imm32", {32'b0, imm32}, {32'b0, e[31:0]});
      checkOutput("imm64", imm64, e);
      checkOutput("sel32", {61'b0, sel32}, {61'b0, s});
      checkOutput("sel64", {61'b0, sel64}, {61'b0, s});
      checkOutput("ill32", {63'b0, ill32}, {63'b0, il});
      checkOutput("ill64", {63'b0, ill64}, {63'b0, il});
      ref_decode(q[0].instr, q[0].sel, 1'b1, e, s, il);
      checkOutput("imma", {32'b0, imma}, {32'b0, e[31:0]});
      checkOutput("sela", {61'b0, sela}, {61'b0, s});
      checkOutput("illa", {63'b0, illa}, {63'b0, il});
    end
  endtask

  // Drives one cycle, checks at the falling edge, advances the model across
  // the rising edge and returns 1 time unit after it.
  task automatic applyStimulus(input bit v, input logic [31:0] ins, input logic [2:0] sel,
                               input bit ordy, input bit fl);
    int  n;
    bit  acc;
    item_t it;
    in_valid   = v;
    in_instr   = ins;
    in_imm_sel = sel;
    out_ready  = ordy;
    flush      = fl;
    @(negedge clk);
    checkAll();
    n   = q.size();
    acc = v && (n < 2);
    if (fl) q.delete();
    else begin
      if (ordy && n > 0) void'(q.pop_front());
      if (acc) begin
        it.instr = ins;
        it.sel   = sel;
        q.push_back(it);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_v32"}, {63'b0, v32}, 64'd0);
    checkOutput({tag, "_v64"}, {63'b0, v64}, 64'd0);
    checkOutput({tag, "_va"},  {63'b0, va},  64'd0);
    checkOutput({tag, "_r32"}, {63'b0, r32}, 64'd1);
    checkOutput({tag, "_imm32"}, {32'b0, imm32}, 64'd0);
    checkOutput({tag, "_imm64"}, imm64, 64'd0);
    checkOutput({tag, "_sel32"}, {61'b0, sel32}, 64'd0);
    checkOutput({tag, "_ill32"}, {63'b0, ill32}, 64'd0);
  endtask

  logic [6:0] ops [10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h7F};

  initial begin
    logic [31:0] r;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_imm_sel = '0;
    #1 reset = 1'b1;
    #1 checkResetOutputs("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] directed formats");
    applyStimulus(1'b1, 32'hFFF00093, 3'b000, 1'b1, 1'b0);
    checkOutput("i_valid32", {63'b0, v32}, 64'd1);
    checkOutput("i_imm32", {32'b0, imm32}, 64'h00000000FFFFFFFF);
    applyStimulus(1'b1, 32'hFE000EE3, 3'b010, 1'b1, 1'b0);
    checkOutput("b_imm32", {32'b0, imm32}, 64'h00000000FFFFFFFC);
    checkOutput("b_imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
    applyStimulus(1'b1, 32'h800000B7, 3'b011, 1'b1, 1'b0);
    checkOutput("u_imm64", imm64, 64'hFFFFFFFF80000000);
    applyStimulus(1'b1, 32'h3401D073, 3'b000, 1'b1, 1'b0);
    checkOutput("z_sela", {61'b0, sela}, 64'd5);
    checkOutput("z_imma", {32'b0, imma}, 64'd3);
    applyStimulus(1'b1, 32'h0000007F, 3'b000, 1'b1, 1'b0);
    checkOutput("op_illa", {63'b0, illa}, 64'd1);
    checkOutput("op_imma", {32'b0, imma}, 64'd0);
    checkOutput("op_sela", {61'b0, sela}, 64'd7);
    applyStimulus(1'b1, 32'h12345013, 3'b110, 1'b1, 1'b0);
    checkOutput("rs_ill32", {63'b0, ill32}, 64'd1);
    checkOutput("rs_imm32", {32'b0, imm32}, 64'd0);
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    checkOutput("drain_v32", {63'b0, v32}, 64'd0);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 32'h00100013, 3'b000, 1'b0, 1'b0);
    checkOutput("bp1_ready", {63'b0, r32}, 64'd1);
    applyStimulus(1'b1, 32'h00200013, 3'b000, 1'b0, 1'b0);
    checkOutput("bp2_ready", {63'b0, r32}, 64'd0);
    checkOutput("bp2_imm", {32'b0, imm32}, 64'd1);
    applyStimulus(1'b1, 32'h00300013, 3'b000, 1'b0, 1'b0);
    checkOutput("bp3_hold", {32'b0, imm32}, 64'd1);
    applyStimulus(1'b1, 32'h00300013, 3'b000, 1'b1, 1'b0);
    checkOutput("bp4_imm", {32'b0, imm32}, 64'd2);
    checkOutput("bp4_ready", {63'b0, r32}, 64'd1);
    applyStimulus(1'b1, 32'h00300013, 3'b000, 1'b1, 1'b0);
    checkOutput("bp5_imm", {32'b0, imm32}, 64'd3);
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    checkOutput("bp6_valid", {63'b0, v32}, 64'd0);

    $display("[TB] flush and mid-stream reset");
    applyStimulus(1'b1, 32'hABC00013, 3'b000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h12300013, 3'b000, 1'b0, 1'b0);
    checkOutput("fl_full", {63'b0, r32}, 64'd0);
    applyStimulus(1'b1, 32'h45600013, 3'b000, 1'b0, 1'b1);
    checkOutput("fl_valid", {63'b0, v32}, 64'd0);
    checkOutput("fl_ready", {63'b0, r32}, 64'd1);
    applyStimulus(1'b1, 32'h78900013, 3'b000, 1'b0, 1'b0);
    checkOutput("mr_loaded", {63'b0, v32}, 64'd1);
    in_valid = 1'b1;
    reset = 1'b1;
    #1 checkResetOutputs("mr");
    @(posedge clk); #1;
    checkOutput("mr_edge_valid", {63'b0, v32}, 64'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    q.delete();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[6:0] = ops[$urandom_range(0, 9)];
      applyStimulus($urandom_range(0, 9) < 7, r, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
    end
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
